vector_alu_seq: RTL and testbench
=================================

# vector_alu_seq

Multi-cycle, parametrised successor to the combinational vector ALU in the execute stage. It accepts one operation through a valid/ready handshake and processes `LANES_PER_CYC` FP16 lanes per clock over `LANES` lanes. It adds a true cross-lane VDOT reduction and a scalar-broadcast SMUL. It returns the full result vector through a second valid/ready handshake, which lets the pipeline stall on backpressure.

## Interface
- `LANES`, 16, number of 16-bit FP16 lanes per vector; vector width `VW = LANES*16`.
- `LANES_PER_CYC`, 4, lanes processed per EXEC beat; must divide `LANES`; `BEATS = LANES/LANES_PER_CYC`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request; high only in IDLE.
- `opcode`  in  4  operation; encodings as in the execute-stage opcode set.
- `op_1`, `op_2`  in  VW  operands; sampled only at acceptance.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  VW  result vector; zero except while out_valid.

## Operation
- Acceptance occurs on a rising edge with `in_valid && in_ready`. It latches opcode, op_1 and op_2.
- FSM states:
  - IDLE: `in_ready=1`. On acceptance, go to EXEC.
  - EXEC: beat counter `b` runs from 0 to BEATS-1. At b==BEATS-1, or after one beat for scalar-class ops, go to DONE.
  - DONE: `out_valid=1`. On `out_ready`, go to IDLE.
- VADD (0000): lane i result = fp_add(op_1[i], op_2[i]).
- VDOT (0001): each beat adds the products op_1[i]*op_2[i] of lanes `b*LANES_PER_CYC` .. `+LANES_PER_CYC-1` into a 16-bit accumulator.
  - Accumulation runs in strictly ascending lane order, with one rounding per add.
  - The accumulator starts at +0.
  - Result lane 0 = accumulator; all other lanes = 0.
- SMUL (0010): lane i result = fp_mul(op_1 lane 0, op_2[i]).
- SST/VLD/VST/J (0011/0100/0101/1000): result = op_1 + op_2 as a VW-bit unsigned add, carry discarded. Scalar-class, one EXEC cycle.
- SLL (0110): result[15:0] = {op_1[15:8], op_2[7:0]}; upper bits 0. Scalar-class.
- SLH (0111): result[15:0] = {op_2[7:0], op_1[7:0]}; upper bits 0. Scalar-class.
- NOP (1111) and any undefined opcode: result = 0. Scalar-class.
- FP16 arithmetic rules (IEEE binary16 layout):
  - Round toward zero.
  - Subnormal inputs and results are flushed to signed zero.
  - Overflow produces signed infinity (0x7C00/0xFC00).
  - Any NaN input, Inf−Inf, or 0×Inf produces 0x7E00.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `result=0`; FSM in IDLE; beat counter and accumulator 0.
- Latency is measured from the acceptance edge to the first cycle with `out_valid=1`:
  - vector ops (VADD/VDOT/SMUL): BEATS+1 cycles;
  - scalar-class ops: 2 cycles.
- Lane results are written into the result register on the beat that computes them. `result` is driven only from the registered value and is gated to 0 when `out_valid=0`.
- While `out_valid && !out_ready`, `result` and `out_valid` hold stable and `in_ready` stays 0.
- `in_ready` rises in the cycle after the output transfer. There is no same-cycle output/input overlap; minimum issue interval is latency+1.
- `in_valid` is ignored outside IDLE, and operand changes after acceptance have no effect.
- An `rst_n` assertion at any point aborts the operation immediately. Outputs go to reset values asynchronously and no partial result is ever presented.

## Structure
- Package `vector_alu_pkg` holds:
  - opcode localparams (VADD … NOP);
  - FP16 constants: QNAN=16'h7E00, PINF=16'h7C00, field widths/bias;
  - an op-class function (vector vs scalar).
- Sub-module `fp16_unit`: combinational fp_add and fp_mul for one lane, per the rules above. It is instantiated `LANES_PER_CYC` times for lane ops. VDOT uses a chain of `LANES_PER_CYC` adders after the multipliers.
- The top level holds the FSM, beat counter, operand/result registers, accumulator, and integer/byte-merge paths.

## Test plan
- VADD with all lanes 0x3C00 + 0x4000 (1.0+2.0) -> every lane 0x4200. With LANES_PER_CYC=4, out_valid appears 5 cycles after acceptance.
- VDOT with all 16 lanes 0x3C00·0x3C00 -> lane 0 = 0x4C00 (16.0), lanes 1–15 = 0. Repeat with LANES_PER_CYC=1 (latency 17) and 16 (latency 2) and check the same value.
- SMUL with op_1 lane0 = 0x4000 and op_2 lanes = 0x4200 -> all lanes 0x4600. Overflow case 0x7BFF·0x4000 -> 0x7C00. Subnormal input 0x0001·0x3C00 -> 0x0000.
- SLL with op_1=0xABCD, op_2=0x12 -> result 0x…0AB12; SLH -> 0x12CD. Upper bits 0 and latency 2.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. result stays stable, in_ready stays 0, and a new in_valid is not accepted until the cycle after the transfer.
- Reset during EXEC (beat 2 of VDOT): outputs reset immediately. After release, in_ready=1, and the next VADD produces a correct result unaffected by the stale accumulator.

Source files
------------

// File: rtl/vector_alu_pkg.sv
// vector_alu_pkg: shared definitions for the sequential vector ALU.
//   - opcode encodings of the execute-stage opcode set
//   - FP16 constants and field helpers (binary16 layout)
//   - FSM state type and the vector/scalar op-class function
package vector_alu_pkg;

  localparam logic [3:0] OP_VADD = 4'h0;
  localparam logic [3:0] OP_VDOT = 4'h1;
  localparam logic [3:0] OP_SMUL = 4'h2;
  localparam logic [3:0] OP_SST  = 4'h3;
  localparam logic [3:0] OP_VLD  = 4'h4;
  localparam logic [3:0] OP_VST  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SLH  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  // Vector ops walk all beats; everything else finishes after one EXEC cycle.
  function automatic logic is_vector_op(input logic [3:0] op);
    return (op == OP_VADD) || (op == OP_VDOT) || (op == OP_SMUL);
  endfunction

  function automatic logic fp_is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
  endfunction

  function automatic logic fp_is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h0);
  endfunction

  // Exponent 0 covers true zeros and subnormals, which are flushed.
  function automatic logic fp_is_zero(input logic [15:0] x);
    return x[14:10] == 5'h0;
  endfunction

endpackage

// File: rtl/vector_alu_seq_fp16_unit.sv
// fp16_unit: combinational FP16 multiply and add for one lane.
//   mul_a, mul_b -> mul_y = mul_a * mul_b
//   add_a, add_b -> add_y = add_a + add_b
// Round toward zero, subnormals flushed to signed zero on input and output,
// overflow to signed infinity, invalid ops and NaN inputs give QNAN.
module fp16_unit
  import vector_alu_pkg::*;
(
  input  logic [15:0] mul_a,
  input  logic [15:0] mul_b,
  input  logic [15:0] add_a,
  input  logic [15:0] add_b,
  output logic [15:0] mul_y,
  output logic [15:0] add_y
);

  // ---------------- multiply ----------------
  logic              m_s;
  logic [21:0]       m_p;
  logic signed [7:0] m_e;
  logic [MAN_W-1:0]  m_man;

  always_comb begin
    m_s   = mul_a[15] ^ mul_b[15];
    m_p   = {1'b1, mul_a[9:0]} * {1'b1, mul_b[9:0]};
    m_e   = $signed({3'b0, mul_a[14:10]}) + $signed({3'b0, mul_b[14:10]})
          - 8'(BIAS) + $signed({7'b0, m_p[21]});
    // Product of two 1.x mantissas is in [1,4); truncation drops the tail.
    m_man = m_p[21] ? 10'(m_p >> 11) : 10'(m_p >> 10);
    mul_y = '0;
    if (fp_is_nan(mul_a) || fp_is_nan(mul_b))
      mul_y = QNAN;
    else if ((fp_is_inf(mul_a) && fp_is_zero(mul_b)) ||
             (fp_is_inf(mul_b) && fp_is_zero(mul_a)))
      mul_y = QNAN;
    else if (fp_is_inf(mul_a) || fp_is_inf(mul_b))
      mul_y = {m_s, PINF[14:0]};
    else if (fp_is_zero(mul_a) || fp_is_zero(mul_b))
      mul_y = {m_s, 15'h0};
    else if (m_e >= 8'sd31)
      mul_y = {m_s, PINF[14:0]};
    else if (m_e <= 8'sd0)
      mul_y = {m_s, 15'h0};
    else
      mul_y = {m_s, m_e[4:0], m_man};
  end

  // ---------------- add ----------------
  // Exponent spread of normals is at most 29, so a 43-bit datapath keeps
  // the aligned sum exact and truncation afterwards is a true RTZ.
  logic [15:0]       a_big, a_sml;
  logic [EXP_W-1:0]  a_d;
  logic [42:0]       a_xa, a_xb, a_xs;
  logic [5:0]        a_msb;
  logic signed [7:0] a_e;
  logic [MAN_W-1:0]  a_man;

  always_comb begin
    a_big = add_a;
    a_sml = add_b;
    if (add_b[14:0] > add_a[14:0]) begin
      a_big = add_b;
      a_sml = add_a;
    end
    a_d  = a_big[14:10] - a_sml[14:10];
    a_xa = {2'b01, a_big[9:0], 31'b0};
    a_xb = {2'b01, a_sml[9:0], 31'b0} >> a_d;
    a_xs = (a_big[15] == a_sml[15]) ? a_xa + a_xb : a_xa - a_xb;
    a_msb = '0;
    for (int i = 0; i < 43; i++)
      if (a_xs[i]) a_msb = 6'(i);
    a_man = 10'((a_xs << (6'd42 - a_msb)) >> 32);
    a_e   = $signed({3'b0, a_big[14:10]}) + $signed({2'b0, a_msb}) - 8'sd41;
    add_y = '0;
    if (fp_is_nan(add_a) || fp_is_nan(add_b))
      add_y = QNAN;
    else if (fp_is_inf(add_a) && fp_is_inf(add_b))
      add_y = (add_a[15] != add_b[15]) ? QNAN : add_a;
    else if (fp_is_inf(add_a))
      add_y = add_a;
    else if (fp_is_inf(add_b))
      add_y = add_b;
    else if (fp_is_zero(add_a) && fp_is_zero(add_b))
      add_y = {add_a[15] & add_b[15], 15'h0};
    else if (fp_is_zero(add_a))
      add_y = add_b;
    else if (fp_is_zero(add_b))
      add_y = add_a;
    else if (a_xs == '0)
      add_y = 16'h0000;               // exact cancellation is +0 under RTZ
    else if (a_e >= 8'sd31)
      add_y = {a_big[15], PINF[14:0]};
    else if (a_e <= 8'sd0)
      add_y = {a_big[15], 15'h0};
    else
      add_y = {a_big[15], a_e[4:0], a_man};
  end

endmodule

// File: rtl/vector_alu_seq.sv
// vector_alu_seq: multi-cycle FP16 vector ALU with valid/ready on both sides.
//   clk, rst_n         clock / async active-low reset
//   in_valid, in_ready request handshake (in_ready only in IDLE)
//   opcode, op_1, op_2 request, captured at acceptance
//   out_valid, out_ready result handshake
//   result             LANES x FP16 result, zero unless out_valid
// LANES_PER_CYC lanes are processed per EXEC beat; VDOT folds each beat's
// products into a 16-bit accumulator through a chain of adders.
module vector_alu_seq
  import vector_alu_pkg::*;
#(
  parameter int LANES         = 16,
  parameter int LANES_PER_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [LANES*16-1:0]   op_1,
  input  logic [LANES*16-1:0]   op_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*16-1:0]   result
);

  localparam int BEATS = LANES / LANES_PER_CYC;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                               state, state_nxt;
  logic [3:0]                           op_q;
  logic [LANES-1:0][15:0]               op1_q, op2_q, res_q, scalar_res;
  logic [15:0]                          acc_q, dot_sum;
  logic [BW-1:0]                        beat;
  logic [LW-1:0]                        base;
  logic                                 dot, smul, last_beat, accept;
  logic [LANES_PER_CYC-1:0][LW-1:0]     lane_idx;
  logic [LANES_PER_CYC-1:0][15:0]       lane_out;

  assign dot       = (op_q == OP_VDOT);
  assign smul      = (op_q == OP_SMUL);
  assign last_beat = !is_vector_op(op_q) || (beat == BW'(BEATS - 1));
  assign base      = LW'(beat * LANES_PER_CYC);
  assign accept    = in_valid && in_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_EXEC;
      end
      S_EXEC: if (last_beat) state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign result = out_valid ? res_q : '0;

  // ---------------- lanes ----------------
  for (genvar j = 0; j < LANES_PER_CYC; j++) begin : g_lane
    logic [LW-1:0] idx;
    logic [15:0]   a_l, b_l, m_a, a_a, a_b, m_y, a_y, chain_in;

    assign idx = base + LW'(j);
    assign a_l = op1_q[idx];
    assign b_l = op2_q[idx];

    // VDOT: lane 0 adds onto the accumulator, each later lane onto the
    // previous lane's sum, preserving ascending lane order.
    if (j == 0) begin : g_head
      assign chain_in = acc_q;
    end else begin : g_tail
      assign chain_in = g_lane[j-1].a_y;
    end

    assign m_a = smul ? op1_q[0] : a_l;
    assign a_a = dot ? chain_in : a_l;
    assign a_b = dot ? m_y : b_l;

    fp16_unit u_fp (
      .mul_a (m_a),
      .mul_b (b_l),
      .add_a (a_a),
      .add_b (a_b),
      .mul_y (m_y),
      .add_y (a_y)
    );

    assign lane_idx[j] = idx;
    assign lane_out[j] = smul ? m_y : a_y;
  end

  assign dot_sum = g_lane[LANES_PER_CYC-1].a_y;

  // ---------------- scalar-class paths ----------------
  always_comb begin
    scalar_res = '0;
    case (op_q)
      OP_SST, OP_VLD, OP_VST, OP_J: scalar_res = op1_q + op2_q;
      OP_SLL: scalar_res[0] = {op1_q[0][15:8], op2_q[0][7:0]};
      OP_SLH: scalar_res[0] = {op2_q[0][7:0], op1_q[0][7:0]};
      OP_NOP: scalar_res = '0;
      default: scalar_res = '0;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      op1_q <= '0;
      op2_q <= '0;
      res_q <= '0;
      acc_q <= '0;
      beat  <= '0;
    end else if (accept) begin
      // Clearing here leaves VDOT's upper lanes zero and drops stale state.
      op_q  <= opcode;
      op1_q <= op_1;
      op2_q <= op_2;
      res_q <= '0;
      acc_q <= '0;
      beat  <= '0;
    end else if (state == S_EXEC) begin
      beat <= beat + 1'b1;
      case (op_q)
        OP_VADD, OP_SMUL:
          for (int j = 0; j < LANES_PER_CYC; j++)
            res_q[lane_idx[j]] <= lane_out[j];
        OP_VDOT: begin
          acc_q <= dot_sum;
          if (last_beat) res_q[0] <= dot_sum;
        end
        default: res_q <= scalar_res;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu_seq.sv
// tb_vector_alu_seq: directed + random checks of vector_alu_seq against a
// real-arithmetic FP16 reference model. Three DUTs differ only in
// LANES_PER_CYC (4, 1, 16). Latency counts the acceptance cycle as 1.
module tb_vector_alu_seq;
  import vector_alu_pkg::*;

  localparam int LANES = 16;
  localparam int VW    = LANES * 16;

  logic          clk, rst_n;
  logic          iv [3];
  logic          orr[3];
  logic          ir [3];
  logic          ov [3];
  logic [3:0]    opcode;
  logic [VW-1:0] op1, op2;
  logic [VW-1:0] res[3];
  int            n_chk, n_fail;

  vector_alu_seq #(.LANES(LANES), .LANES_PER_CYC(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .opcode(opcode),
    .op_1(op1), .op_2(op2), .out_valid(ov[0]), .out_ready(orr[0]), .result(res[0]));
  vector_alu_seq #(.LANES(LANES), .LANES_PER_CYC(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .opcode(opcode),
    .op_1(op1), .op_2(op2), .out_valid(ov[1]), .out_ready(orr[1]), .result(res[1]));
  vector_alu_seq #(.LANES(LANES), .LANES_PER_CYC(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .opcode(opcode),
    .op_1(op1), .op_2(op2), .out_valid(ov[2]), .out_ready(orr[2]), .result(res[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic isnan(input logic [15:0] x);
    return x[14:10] == 5'h1F && x[9:0] != 0;
  endfunction
  function automatic logic isinf(input logic [15:0] x);
    return x[14:10] == 5'h1F && x[9:0] == 0;
  endfunction
  function automatic logic iszero(input logic [15:0] x);
    return x[14:10] == 5'h0;
  endfunction

  function automatic real f2r(input logic [15:0] x);
    real v;
    if (x[14:10] == 0) return 0.0;
    v = 1.0 + real'(x[9:0]) / 1024.0;
    for (int e = 15; e < int'(x[14:10]); e++) v = v * 2.0;
    for (int e = int'(x[14:10]); e < 15; e++) v = v / 2.0;
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2f(input logic s, input real mag);
    real m;
    int  e, f;
    if (mag >= 65536.0) return {s, 15'h7C00};
    if (mag < 1.0 / 16384.0) return {s, 15'h0};
    m = mag;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f = $rtoi((m - 1.0) * 1024.0);
    return {s, 5'(e), 10'(f)};
  endfunction

  function automatic logic [15:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
    logic s;
    s = a[15] ^ b[15];
    if (isnan(a) || isnan(b)) return 16'h7E00;
    if ((isinf(a) && iszero(b)) || (isinf(b) && iszero(a))) return 16'h7E00;
    if (isinf(a) || isinf(b)) return {s, 15'h7C00};
    if (iszero(a) || iszero(b)) return {s, 15'h0};
    return r2f(s, (f2r(a) * f2r(b)) * (s ? -1.0 : 1.0));
  endfunction

  function automatic logic [15:0] add_ref(input logic [15:0] a, input logic [15:0] b);
    real r;
    if (isnan(a) || isnan(b)) return 16'h7E00;
    if (isinf(a) && isinf(b)) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (isinf(a)) return a;
    if (isinf(b)) return b;
    if (iszero(a) && iszero(b)) return {a[15] & b[15], 15'h0};
    r = f2r(a) + f2r(b);
    if (r == 0.0) return 16'h0000;
    return r2f(r < 0.0, (r < 0.0) ? -r : r);
  endfunction

  function automatic logic [VW-1:0] model(input logic [3:0] opc, input logic [VW-1:0] a,
                                          input logic [VW-1:0] b);
    logic [VW-1:0] r;
    logic [15:0]   acc;
    r = '0;
    case (opc)
      OP_VADD: for (int i = 0; i < LANES; i++) r[i*16 +: 16] = add_ref(a[i*16 +: 16], b[i*16 +: 16]);
      OP_SMUL: for (int i = 0; i < LANES; i++) r[i*16 +: 16] = mul_ref(a[15:0], b[i*16 +: 16]);
      OP_VDOT: begin
        acc = 16'h0000;
        for (int i = 0; i < LANES; i++) acc = add_ref(acc, mul_ref(a[i*16 +: 16], b[i*16 +: 16]));
        r[15:0] = acc;
      end
      OP_SST, OP_VLD, OP_VST, OP_J: r = a + b;
      OP_SLL: r[15:0] = {a[15:8], b[7:0]};
      OP_SLH: r[15:0] = {b[7:0], a[7:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] rand_fp();
    logic [15:0] sp[6];
    sp = '{16'h7C00, 16'hFC00, 16'h7E01, 16'h0003, 16'h8000, 16'h7BFF};
    if ($urandom_range(0, 9) == 0) return sp[$urandom_range(0, 5)];
    return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*16 +: 16] = rand_fp();
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_raw();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [VW-1:0] rep(input logic [15:0] x);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*16 +: 16] = x;
    return v;
  endfunction

  function automatic int lpc(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 16;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present a request, check it is accepted, then scramble the operands.
  task automatic issue(input int k, input logic [3:0] opc, input logic [VW-1:0] a,
                       input logic [VW-1:0] b);
    opcode = opc;
    op1    = a;
    op2    = b;
    iv[k]  = 1'b1;
    chk("in_ready_before_issue", VW'(ir[k]), VW'(1));
    @(posedge clk); #1;
    iv[k]  = 1'b0;
    opcode = 4'($urandom);
    op1    = rand_raw();
    op2    = rand_raw();
  endtask

  task automatic wait_ov(input int k, output int lat);
    lat = 1;
    while (!ov[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input int k, input logic [3:0] opc, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic [VW-1:0] expv,
                        input int explat, input string tag);
    int lat;
    orr[k] = 1'b1;
    issue(k, opc, a, b);
    wait_ov(k, lat);
    chk({tag, "_result"}, res[k], expv);
    chk({tag, "_latency"}, VW'(lat), VW'(explat));
    @(posedge clk); #1;
    chk({tag, "_ov_after"}, VW'(ov[k]), VW'(0));
    chk({tag, "_ir_after"}, VW'(ir[k]), VW'(1));
    chk({tag, "_res_after"}, res[k], '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [VW-1:0] a, b, r0;
    logic [3:0]    ops[11];
    logic [3:0]    opc;
    int            lat, k, explat;

    ops = '{OP_VADD, OP_VDOT, OP_SMUL, OP_SST, OP_VLD, OP_VST, OP_SLL, OP_SLH, OP_J, OP_NOP, 4'hB};
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    opcode = '0;
    op1    = '0;
    op2    = '0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; orr[i] = 1'b1; end

    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", VW'(ir[i]), VW'(1));
      chk("reset_out_valid", VW'(ov[i]), VW'(0));
      chk("reset_result", res[i], '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed function checks
    run_op(0, OP_VADD, rep(16'h3C00), rep(16'h4000), rep(16'h4200), 5, "vadd_1p2");
    run_op(0, OP_VDOT, rep(16'h3C00), rep(16'h3C00), VW'(16'h4C00), 5, "vdot_lpc4");
    run_op(1, OP_VDOT, rep(16'h3C00), rep(16'h3C00), VW'(16'h4C00), 17, "vdot_lpc1");
    run_op(2, OP_VDOT, rep(16'h3C00), rep(16'h3C00), VW'(16'h4C00), 2, "vdot_lpc16");
    run_op(0, OP_SMUL, VW'(16'h4000), rep(16'h4200), rep(16'h4600), 5, "smul_2x3");
    run_op(0, OP_SMUL, VW'(16'h7BFF), rep(16'h4000), rep(16'h7C00), 5, "smul_overflow");
    run_op(0, OP_SMUL, VW'(16'h0001), rep(16'h3C00), rep(16'h0000), 5, "smul_subnormal");
    run_op(0, OP_SLL, VW'(16'hABCD), VW'(16'h0012), VW'(16'hAB12), 2, "sll");
    run_op(0, OP_SLH, VW'(16'hABCD), VW'(16'h0012), VW'(16'h12CD), 2, "slh");
    a = rand_raw();
    b = rand_raw();
    run_op(0, OP_SST, a, b, a + b, 2, "sst_wide_add");
    run_op(2, OP_NOP, a, b, '0, 2, "nop");
    run_op(1, 4'hC, a, b, '0, 2, "undef_op");

    // Backpressure: hold the result, keep a competing request pending
    a = rand_vec();
    b = rand_vec();
    orr[0] = 1'b0;
    issue(0, OP_VADD, a, b);
    wait_ov(0, lat);
    r0 = res[0];
    chk("bp_result", r0, model(OP_VADD, a, b));
    opcode = OP_SLL;
    op1    = VW'(16'hABCD);
    op2    = VW'(16'h0012);
    iv[0]  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", res[0], r0);
      chk("bp_hold_valid", VW'(ov[0]), VW'(1));
      chk("bp_hold_in_ready", VW'(ir[0]), VW'(0));
    end
    orr[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_xfer_valid", VW'(ov[0]), VW'(0));
    chk("bp_xfer_in_ready", VW'(ir[0]), VW'(1));
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("bp_accept_next", VW'(ir[0]), VW'(0));
    wait_ov(0, lat);
    chk("bp_next_result", res[0], VW'(16'hAB12));
    chk("bp_next_latency", VW'(lat), VW'(2));
    @(posedge clk); #1;

    // Reset during beat 2 of a VDOT
    issue(0, OP_VDOT, rep(16'h4000), rep(16'h4000));
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", VW'(ir[0]), VW'(1));
    chk("rst_mid_out_valid", VW'(ov[0]), VW'(0));
    chk("rst_mid_result", res[0], '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_release_in_ready", VW'(ir[0]), VW'(1));
    run_op(0, OP_VADD, rep(16'h3C00), rep(16'h4000), rep(16'h4200), 5, "post_rst_vadd");
    run_op(0, OP_VDOT, rep(16'h3C00), rep(16'h3C00), VW'(16'h4C00), 5, "post_rst_vdot");

    // Random ops across all three lane widths
    for (int i = 0; i < 24; i++) begin
      k   = i % 3;
      opc = ops[$urandom_range(0, 10)];
      if (is_vector_op(opc)) begin
        a = rand_vec();
        b = rand_vec();
        explat = LANES / lpc(k) + 1;
      end else begin
        a = rand_raw();
        b = rand_raw();
        explat = 2;
      end
      run_op(k, opc, a, b, model(opc, a, b), explat, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
